servo_pwm_gen: RTL and testbench



---
 rtl/servo_pwm_gen.sv | 181 ++++++++++++++++++
 tb/tb_servo_pwm_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
// Regenerates NUM_CH synchronous servo/ESC PWM outputs from decoded channel
// widths. Each width is given in microseconds and is clamped into
// [MIN_US, MAX_US] on capture. Captured widths are double-buffered:
// ch_valid writes the shadow set, and each frame boundary copies shadow to
// active. If no channel set arrives for TIMEOUT_FRAMES consecutive frames,
// every output is driven at FAILSAFE_US.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   ch_in        channel widths in us, channel k at [16k+15:16k], unsigned
//   ch_valid     one-cycle strobe, ch_in holds a complete new channel set
//   pwm_out      servo pulse outputs, bit k = channel k (registered)
//   frame_start  one-cycle pulse in the first cycle of each PWM frame
//   failsafe     high while the failsafe widths are in use
module servo_pwm_gen #(
  parameter int CLK_PER_US     = 50,
  parameter int NUM_CH         = 6,
  parameter int FRAME_US       = 20000,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int FAILSAFE_US    = 1500,
  parameter int TIMEOUT_FRAMES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [16*NUM_CH-1:0]   ch_in,
  input  logic                   ch_valid,
  output logic [NUM_CH-1:0]      pwm_out,
  output logic                   frame_start,
  output logic                   failsafe
);

  // Counter widths; a width of at least 1 keeps degenerate parameters legal.
  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(FRAME_US - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_FRAMES);

  localparam logic [15:0] MIN_W = 16'(MIN_US);
  localparam logic [15:0] MAX_W = 16'(MAX_US);
  localparam logic [15:0] FS_W  = 16'(FAILSAFE_US);

  // ---------------------------------------------------------------------
  // Microsecond timebase
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] presc_reg;
  logic [US_W-1:0]  us_cnt_reg;
  logic             tick;
  logic             boundary;

  assign tick     = (presc_reg == PRE_LAST);
  assign boundary = tick && (us_cnt_reg == US_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      us_cnt_reg <= '0;
    end else if (boundary) begin
      us_cnt_reg <= '0;
    end else if (tick) begin
      us_cnt_reg <= us_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Link-loss supervision
  // ---------------------------------------------------------------------
  // seen_valid_reg remembers whether any channel set arrived during the
  // current frame; each boundary without one bumps the saturating count.
  logic            seen_valid_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic [TO_W-1:0] to_cnt_inc;
  logic            timeout_hit;

  assign to_cnt_inc = (to_cnt_reg == TO_LIMIT) ? TO_LIMIT : to_cnt_reg + 1'b1;

  // A strobe on the boundary cycle counts as fresh data, so it vetoes the
  // timeout even though its widths only land at the following boundary.
  assign timeout_hit = boundary && !ch_valid && !seen_valid_reg &&
                       (to_cnt_inc == TO_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_valid_reg <= 1'b0;
      to_cnt_reg     <= '0;
      failsafe       <= 1'b1;
    end else if (ch_valid) begin
      seen_valid_reg <= 1'b1;
      to_cnt_reg     <= '0;
      failsafe       <= 1'b0;
    end else if (boundary) begin
      if (!seen_valid_reg) begin
        to_cnt_reg <= to_cnt_inc;
      end
      seen_valid_reg <= 1'b0;
      if (timeout_hit) begin
        failsafe <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel capture, double buffer and pulse generation
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [15:0] raw;
      logic [15:0] clamped;
      logic [15:0] shadow_reg;
      logic [15:0] active_reg;
      logic        pwm_reg;

      assign raw = ch_in[16*gi +: 16];

      always_comb begin
        clamped = raw;
        if (raw < MIN_W) begin
          clamped = MIN_W;
        end else if (raw > MAX_W) begin
          clamped = MAX_W;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_reg <= FS_W;
        end else if (ch_valid) begin
          shadow_reg <= clamped;
        end else if (timeout_hit) begin
          shadow_reg <= FS_W;
        end
      end

      // Active only changes on a boundary, so a pulse already in progress
      // always completes with the width it started with.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          active_reg <= FS_W;
        end else if (boundary) begin
          active_reg <= timeout_hit ? FS_W : shadow_reg;
        end
      end

      // Each us_cnt value lasts CLK_PER_US cycles, so the output is high for
      // exactly active*CLK_PER_US cycles, starting one cycle after us_cnt=0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pwm_reg <= 1'b0;
        end else begin
          pwm_reg <= (32'(us_cnt_reg) < 32'(active_reg));
        end
      end

      assign pwm_out[gi] = pwm_reg;
    end
  endgenerate

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Testbench for servo_pwm_gen. Runs with a scaled timebase so that whole
// frames are short; each frame is measured cycle by cycle (pulse length and
// rise offset per channel, frame_start position, failsafe level) and checked
// against a frame-level reference model of the capture/timeout rules.
module tb_servo_pwm_gen;
  localparam int CPU  = 4;
  localparam int NCH  = 6;
  localparam int FRM  = 40;
  localparam int MINU = 10;
  localparam int MAXU = 20;
  localparam int FSU  = 15;
  localparam int TOF  = 5;
  localparam int FC   = CPU * FRM;   // clock cycles per frame

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [16*NCH-1:0]    ch_in = '0;
  logic                 ch_valid = 1'b0;
  logic [NCH-1:0]       pwm_out;
  logic                 frame_start;
  logic                 failsafe;

  int checks = 0;
  int failures = 0;

  // Reference model state (frame-level)
  int m_shadow[NCH];
  int m_active[NCH];
  int m_tcnt;
  bit m_seen;
  bit m_fs;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .CLK_PER_US(CPU), .NUM_CH(NCH), .FRAME_US(FRM), .MIN_US(MINU),
    .MAX_US(MAXU), .FAILSAFE_US(FSU), .TIMEOUT_FRAMES(TOF)
  ) dut (
    .clk(clk), .rst(rst), .ch_in(ch_in), .ch_valid(ch_valid),
    .pwm_out(pwm_out), .frame_start(frame_start), .failsafe(failsafe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v < MINU) return MINU;
    if (v > MAXU) return MAXU;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_shadow[k] = FSU;
      m_active[k] = FSU;
    end
    m_tcnt = 0;
    m_seen = 0;
    m_fs   = 1;
  endtask

  task automatic model_valid();
    for (int k = 0; k < NCH; k++) m_shadow[k] = clampv(int'(ch_in[16*k +: 16]));
    m_seen = 1;
    m_tcnt = 0;
    m_fs   = 0;
  endtask

  // End of a frame. valid_here: the strobe landed on the boundary cycle itself.
  task automatic model_boundary(input bit valid_here);
    bit hit;
    hit = 0;
    if (valid_here) begin
      for (int k = 0; k < NCH; k++) m_active[k] = m_shadow[k];
      model_valid();
    end else begin
      if (!m_seen) begin
        m_tcnt = (m_tcnt < TOF) ? m_tcnt + 1 : TOF;
        hit = (m_tcnt == TOF);
      end
      m_seen = 0;
      if (hit) begin
        m_fs = 1;
        for (int k = 0; k < NCH; k++) m_shadow[k] = FSU;
      end
      for (int k = 0; k < NCH; k++) m_active[k] = m_shadow[k];
    end
  endtask

  task automatic set_inputs(input int v0, input int v1, input int v2,
                            input int v3, input int v4, input int v5);
    ch_in = {16'(v5), 16'(v4), 16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endtask

  // Entered at the negedge of the first cycle of a frame; returns at the
  // negedge of the first cycle of the next frame. valid_off<0: no strobe.
  task automatic run_frame(input string name, input int valid_off, input bit after_reset);
    int hi[NCH];
    int first[NCH];
    int exp_w[NCH];
    int extra_fs;
    for (int k = 0; k < NCH; k++) begin
      hi[k] = 0;
      first[k] = -1;
      exp_w[k] = m_active[k];
    end
    extra_fs = 0;
    check($sformatf("%s frame_start", name), 32'(frame_start), after_reset ? 32'd0 : 32'd1);
    check($sformatf("%s failsafe_at_start", name), 32'(failsafe), 32'(m_fs));
    for (int off = 0; off < FC; off++) begin
      if (off > 0 && frame_start) extra_fs++;
      if (valid_off >= 0 && off == valid_off + 1)
        check($sformatf("%s failsafe_after_valid", name), 32'(failsafe), 32'd0);
      for (int k = 0; k < NCH; k++) begin
        if (pwm_out[k] === 1'b1) begin
          hi[k]++;
          if (first[k] < 0) first[k] = off;
        end
      end
      ch_valid = (off == valid_off);
      @(negedge clk);
    end
    ch_valid = 1'b0;
    check($sformatf("%s extra_frame_start", name), 32'(extra_fs), 32'd0);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("%s ch%0d high_cycles", name, k), 32'(hi[k]), 32'(exp_w[k] * CPU));
      check($sformatf("%s ch%0d rise_offset", name, k), 32'(first[k]), 32'd1);
    end
    $display("frame %s valid_off=%0d widths_us=%0d,%0d,%0d,%0d,%0d,%0d failsafe_next=%0d",
             name, valid_off, exp_w[0], exp_w[1], exp_w[2], exp_w[3], exp_w[4], exp_w[5],
             (valid_off >= 0) ? 0 : -1);
    if (valid_off >= 0 && valid_off < FC - 1) model_valid();
    model_boundary(valid_off == FC - 1);
  endtask

  initial begin
    int r;
    int voff;
    logic [15:0] v[NCH];

    // Reset state
    repeat (2) @(negedge clk);
    check("reset pwm_out", 32'(pwm_out), 32'd0);
    check("reset frame_start", 32'(frame_start), 32'd0);
    check("reset failsafe", 32'(failsafe), 32'd1);
    rst = 1'b0;
    model_reset();

    // Idle after reset: failsafe widths
    run_frame("idle0", -1, 1'b1);
    run_frame("idle1", -1, 1'b0);

    // Mid-frame strobe: current frame untouched, next frame uses new widths
    set_inputs(10, 13, 15, 17, 20, 11);
    run_frame("mid_valid", 5 * CPU, 1'b0);
    run_frame("mid_apply", -1, 1'b0);

    // Clamping of out-of-range inputs
    set_inputs(5, 25, 0, 65535, 9, 21);
    run_frame("clamp_valid", 30 * CPU + 1, 1'b0);
    run_frame("clamp_apply", -1, 1'b0);

    // Strobe exactly on the boundary cycle
    set_inputs(12, 14, 16, 18, 19, 20);
    run_frame("bnd_valid", FC - 1, 1'b0);
    run_frame("bnd_old", -1, 1'b0);
    run_frame("bnd_new", -1, 1'b0);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < NCH; k++) begin
        r = $urandom_range(0, 3);
        case (r)
          0: v[k] = 16'($urandom_range(MINU, MAXU));
          1: v[k] = 16'($urandom_range(0, MINU - 1));
          2: v[k] = 16'($urandom_range(MAXU + 1, 200));
          default: v[k] = 16'($urandom);
        endcase
      end
      set_inputs(v[0], v[1], v[2], v[3], v[4], v[5]);
      r = $urandom_range(0, 3);
      if (r == 0) voff = -1;
      else if (r == 3) voff = FC - 1;
      else voff = $urandom_range(0, FC - 2);
      run_frame($sformatf("rand%0d", f), voff, 1'b0);
    end

    // Link loss: data once, then silence long enough to reach failsafe
    set_inputs(11, 19, 13, 17, 20, 10);
    run_frame("to_valid", 7 * CPU, 1'b0);
    for (int f = 0; f < 7; f++) run_frame($sformatf("to_idle%0d", f), -1, 1'b0);
    set_inputs(18, 12, 20, 10, 16, 14);
    run_frame("to_restore", 2 * CPU, 1'b0);
    run_frame("to_restored", -1, 1'b0);

    // Reset in the middle of a long pulse
    set_inputs(17, 17, 17, 17, 17, 17);
    run_frame("rst_load", 3 * CPU, 1'b0);
    repeat (10 * CPU) @(negedge clk);
    check("rst pulse_active", 32'(pwm_out), 32'((1 << NCH) - 1));
    #1 rst = 1'b1;
    #1;
    check("rst pwm_drop", 32'(pwm_out), 32'd0);
    check("rst failsafe", 32'(failsafe), 32'd1);
    check("rst frame_start", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frame("post_rst0", -1, 1'b1);
    run_frame("post_rst1", -1, 1'b0);
    check("final frame_start", 32'(frame_start), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #5ms;
    $display("FAIL timeout simulation_time_limit observed=expired required=finished");
    $fatal(1, "time limit");
  end

endmodule
